// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter: one bit position per clock, logical or arithmetic fill.
// Optional rotate mode is enabled by defining SEQ_SHIFT_RIGHT_ROTATE_EN.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// SHIFT | one right-shift step per cycle until the count is exhausted
// DONE  | one-cycle done pulse; dout holds the result
module seq_shift_right #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  din,
    input  logic [SW-1:0] shamt,
    input  logic          arith,
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
    input  logic          rot,
`endif
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [N-1:0]  dout_q, dout_d;
    logic          fill;
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
    logic          rot_q, rot_d;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
        rot_d   = rot_q;
        // Rotate takes priority over sign fill.
        fill    = rot_q ? shreg_q[0] : (mode_q & shreg_q[N-1]);
`else
        fill    = mode_q & shreg_q[N-1];
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = shamt;
                    mode_d  = arith;
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
                    rot_d   = rot;
`endif
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    shreg_d = {fill, shreg_q[N-1:1]};
                    cnt_d   = cnt_q - SW'(1);
                end else begin
                    state_d = DONE;
                    dout_d  = shreg_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_seq_shift_right.sv
// Scoreboard bench for seq_shift_right (N=8): stimulus pushes expected result and
// done cycle; a negedge monitor pops and compares on every done pulse.
module tb_seq_shift_right;

    localparam int N  = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  din;
    logic [SW-1:0] shamt;
    logic          arith;
    logic          rot;
    logic          busy;
    logic          done;
    logic [N-1:0]  dout;

    seq_shift_right #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .shamt (shamt),
        .arith (arith),
`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
        .rot   (rot),
`endif
        .busy  (busy),
        .done  (done),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] dout;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("dout", {24'd0, dout}, {24'd0, e.dout});
                check("done_cycle", cyc, e.at);
            end
        end
    end

    // Issue one request; returns at the negedge just after the accepting edge,
    // with the inputs scrambled to prove they were captured.
    task automatic issue(input logic [N-1:0] d, input logic [SW-1:0] s, input logic a,
                         input logic r, input logic [N-1:0] exp, input bit push);
        @(negedge clk);
        din   = d;
        shamt = s;
        arith = a;
        rot   = r;
        start = 1'b1;
        if (push) sb.push_back('{exp, cyc + 1 + int'(s) + 1});
        @(negedge clk);
        start = 1'b0;
        din   = ~d;
        shamt = ~s;
        arith = ~a;
        rot   = ~r;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        shamt = '0;
        arith = 1'b0;
        rot   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", {24'd0, dout}, 32'd0);
        rst_n = 1'b1;

        // Logical shift by 3; busy spans 4 SHIFT cycles plus DONE.
        issue(8'hB4, 3'd3, 1'b0, 1'b0, 8'h16, 1'b1);
        check("busy_0", {31'd0, busy}, 32'd1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("busy_fall", {31'd0, busy}, 32'd0);
        wait_idle();
        check("dout_hold_16", {24'd0, dout}, 32'h16);

        issue(8'hB4, 3'd3, 1'b1, 1'b0, 8'hF6, 1'b1);
        wait_idle();
        issue(8'hB4, 3'd0, 1'b0, 1'b0, 8'hB4, 1'b1);
        wait_idle();
        issue(8'h80, 3'd7, 1'b0, 1'b0, 8'h01, 1'b1);
        wait_idle();
        issue(8'h80, 3'd7, 1'b1, 1'b0, 8'hFF, 1'b1);
        wait_idle();
        issue(8'h3C, 3'd2, 1'b1, 1'b0, 8'h0F, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);
        check("dout_hold_0f", {24'd0, dout}, 32'h0F);

        // A start while busy must be ignored (monitor flags any extra done).
        issue(8'hB4, 3'd3, 1'b0, 1'b0, 8'h16, 1'b1);
        @(negedge clk);
        din   = 8'hFF;
        shamt = 3'd0;
        arith = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);
        check("ignored_start_dout", {24'd0, dout}, 32'h16);

        // Reset mid-operation abandons it with no done.
        issue(8'hB4, 3'd3, 1'b0, 1'b0, 8'h16, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_dout", {24'd0, dout}, 32'd0);
        repeat (10) @(negedge clk);
        issue(8'h5A, 3'd1, 1'b0, 1'b0, 8'h2D, 1'b1);
        wait_idle();

`ifdef SEQ_SHIFT_RIGHT_ROTATE_EN
        issue(8'hB4, 3'd3, 1'b1, 1'b1, 8'h96, 1'b1);
        wait_idle();
        issue(8'hB4, 3'd3, 1'b1, 1'b0, 8'hF6, 1'b1);
        wait_idle();
        issue(8'h01, 3'd1, 1'b0, 1'b1, 8'h80, 1'b1);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
